// File: rtl/skyking_pkg.sv
// SkyKing video timing package: default 640x480@60 timing values, sync
// polarity encoding, the coordinate type and a window-decode helper.
package skyking_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CW_DEF       = 10;

    // Sync polarity encoding: the value a sync output takes while active.
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef logic [CW_DEF-1:0] coord_t;

    // True when lo <= pos < hi.
    function automatic logic in_window(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/skyking_wrap_counter.sv
// Modulo-MOD counter: advances on inc, wraps MOD-1 -> 0 with a wrap flag.
// Resets to MOD-1 so that the first increment lands on 0 and reports a wrap.
// The next value is exported so the parent can register decodes in step.
module skyking_wrap_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic [W-1:0] q_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Next-count and wrap detection.
    always_comb begin
        wrap   = 1'b0;
        q_next = q;
        if (inc) begin
            if (q == LAST) begin
                wrap   = 1'b1;
                q_next = '0;
            end else begin
                q_next = q + W'(1);
            end
        end else begin
            q_next = q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LAST;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/skyking_vga_timing.sv
// SkyKing video timing generator: pixel/line counters, sync and blanking
// decodes, line/frame start pulses. All outputs are registered and the
// decodes are registered from the counters' next values so they always
// agree with the hpos/vpos presented.
// Optional feature: define SKYKING_FRAME_CNT_EN to add the 8-bit frame_cnt
// port (resets to 8'hFF so the first frame after reset reads 0).
module skyking_vga_timing import skyking_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start
`ifdef SKYKING_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

    logic [CW-1:0] h_q_s, h_next_s, v_q_s, v_next_s;
    logic          h_wrap_s, v_wrap_s, v_inc_s;
    logic          hsync_r, vsync_r, display_on_r, line_start_r, frame_start_r;

    assign v_inc_s = pix_en & h_wrap_s;

    skyking_wrap_counter #(.MOD(H_TOTAL), .W(CW)) u_hcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (pix_en),
        .q      (h_q_s),
        .q_next (h_next_s),
        .wrap   (h_wrap_s)
    );

    skyking_wrap_counter #(.MOD(V_TOTAL), .W(CW)) u_vcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (v_inc_s),
        .q      (v_q_s),
        .q_next (v_next_s),
        .wrap   (v_wrap_s)
    );

    // Sync/blank decodes follow the counters on strobes and hold otherwise;
    // the wrap flags already include pix_en, so pulses drop without a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            display_on_r  <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            line_start_r  <= h_wrap_s;
            frame_start_r <= v_wrap_s;
            if (pix_en) begin
                hsync_r      <= in_window(int'(h_next_s), HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
                vsync_r      <= in_window(int'(v_next_s), VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
                display_on_r <= (int'(h_next_s) < H_ACTIVE) && (int'(v_next_s) < V_ACTIVE);
            end else begin
                hsync_r      <= hsync_r;
                vsync_r      <= vsync_r;
                display_on_r <= display_on_r;
            end
        end
    end

`ifdef SKYKING_FRAME_CNT_EN
    logic [7:0] frame_cnt_r;

    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 8'hFF;
        end else if (v_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

    assign hpos        = h_q_s;
    assign vpos        = v_q_s;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign display_on  = display_on_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_skyking_vga_timing.sv
// Bench for skyking_vga_timing: one default-timing instance (active-low
// syncs) and one short-timing instance (4/1/1/1 both axes, active-high
// syncs) share clock, reset and pixel strobe. A strobe-count model derives
// every output from the frame position and is compared each cycle.
module tb_skyking_vga_timing;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_hsync, d_vsync, d_disp, d_ls, d_fs;
    logic       s_hsync, s_vsync, s_disp, s_ls, s_fs;
`ifdef SKYKING_FRAME_CNT_EN
    logic [7:0] d_fc, s_fc;
`endif

    int total = 0;
    int bad   = 0;
    int strobes;
    bit last_en;

    always #5 clk = ~clk;

    skyking_vga_timing u_def (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
        .display_on(d_disp), .line_start(d_ls), .frame_start(d_fs)
`ifdef SKYKING_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    skyking_vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(10)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_disp), .line_start(s_ls), .frame_start(s_fs)
`ifdef SKYKING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs after s pixel strobes since reset: position is simply
    // (s-1) modulo the frame size; le = whether the last edge was a strobe.
    function automatic void model(input int s, input int ha, input int hfp, input int hs, input int hbp,
                                  input int va, input int vfp, input int vs, input int vbp,
                                  input bit pol, input bit le,
                                  output int h, output int v, output int hsy, output int vsy,
                                  output int disp, output int ls, output int fs, output int fc);
        int ht, vt, p;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        if (s == 0) begin
            h = ht - 1; v = vt - 1;
            hsy = int'(!pol); vsy = int'(!pol);
            disp = 0; ls = 0; fs = 0; fc = 255;
        end else begin
            p    = (s - 1) % (ht * vt);
            h    = p % ht;
            v    = p / ht;
            hsy  = (h >= ha + hfp && h < ha + hfp + hs) ? int'(pol) : int'(!pol);
            vsy  = (v >= va + vfp && v < va + vfp + vs) ? int'(pol) : int'(!pol);
            disp = (h < ha && v < va) ? 1 : 0;
            ls   = (le && h == 0) ? 1 : 0;
            fs   = (le && p == 0) ? 1 : 0;
            fc   = ((s - 1) / (ht * vt)) % 256;
        end
    endfunction

    // Strobe count and last-edge strobe flag for the model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobes <= 0;
            last_en <= 1'b0;
        end else begin
            if (pix_en) strobes <= strobes + 1;
            last_en <= pix_en;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int h, v, hsy, vsy, disp, ls, fs, fc;
        model(strobes, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, last_en, h, v, hsy, vsy, disp, ls, fs, fc);
        chk("d_hpos", int'(d_hpos), h);
        chk("d_vpos", int'(d_vpos), v);
        chk("d_hsync", int'(d_hsync), hsy);
        chk("d_vsync", int'(d_vsync), vsy);
        chk("d_display_on", int'(d_disp), disp);
        chk("d_line_start", int'(d_ls), ls);
        chk("d_frame_start", int'(d_fs), fs);
`ifdef SKYKING_FRAME_CNT_EN
        chk("d_frame_cnt", int'(d_fc), fc);
`endif
        model(strobes, 4, 1, 1, 1, 4, 1, 1, 1, 1'b1, last_en, h, v, hsy, vsy, disp, ls, fs, fc);
        chk("s_hpos", int'(s_hpos), h);
        chk("s_vpos", int'(s_vpos), v);
        chk("s_hsync", int'(s_hsync), hsy);
        chk("s_vsync", int'(s_vsync), vsy);
        chk("s_display_on", int'(s_disp), disp);
        chk("s_line_start", int'(s_ls), ls);
        chk("s_frame_start", int'(s_fs), fs);
`ifdef SKYKING_FRAME_CNT_EN
        chk("s_frame_cnt", int'(s_fc), fc);
`endif
    end

    initial begin
        int hs_cnt, disp_cnt, ls_cnt, last_fs, fs_seen;
        rst_n  = 1'b0;
        pix_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, pinned by hand.
        chk("rst_d_hpos", int'(d_hpos), 799);
        chk("rst_d_vpos", int'(d_vpos), 524);
        chk("rst_d_hsync", int'(d_hsync), 1);
        chk("rst_s_hpos", int'(s_hpos), 6);
        chk("rst_s_hsync", int'(s_hsync), 0);

        // First strobe lands on (0,0) with frame_start.
        rst_n  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        chk("first_d_hpos", int'(d_hpos), 0);
        chk("first_d_disp", int'(d_disp), 1);
        chk("first_d_fs", int'(d_fs), 1);
        chk("first_s_fs", int'(s_fs), 1);

        // One full default line: count hsync/display/line_start over 800 clks.
        hs_cnt = 0; disp_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (d_hsync == 1'b0) hs_cnt++;
            if (d_disp) disp_cnt++;
            if (d_ls) ls_cnt++;
            if (i == 1)   chk("second_d_fs", int'(d_fs), 0);
            if (i == 655) chk("d_hsync_at_655", int'(d_hsync), 1);
            if (i == 656) chk("d_hsync_at_656", int'(d_hsync), 0);
            if (i == 751) chk("d_hsync_at_751", int'(d_hsync), 0);
            if (i == 752) chk("d_hsync_at_752", int'(d_hsync), 1);
            @(negedge clk);
        end
        chk("line_hsync_clks", hs_cnt, 96);
        chk("line_display_clks", disp_cnt, 640);
        chk("line_ls_count", ls_cnt, 1);
        chk("line2_d_ls", int'(d_ls), 1);
        chk("line2_d_hpos", int'(d_hpos), 0);
        chk("line2_d_vpos", int'(d_vpos), 1);

        // 25% strobe duty: short-timing frame period becomes 4 x 49 clks.
        last_fs = -1; fs_seen = 0;
        for (int i = 0; i < 600; i++) begin
            pix_en = (i % 4 == 0);
            @(negedge clk);
            if (s_fs) begin
                fs_seen++;
                if (last_fs >= 0) chk("s_fs_period_x4", i - last_fs, 196);
                last_fs = i;
            end
        end
        chk("s_fs_seen", fs_seen, 3);

        // Run to (5,5) on the short timing: both syncs active.
        pix_en = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pix_en = 1'b1;
        repeat (41) @(negedge clk);
        chk("pre_s_hpos", int'(s_hpos), 5);
        chk("pre_s_vpos", int'(s_vpos), 5);
        chk("pre_s_hsync", int'(s_hsync), 1);
        chk("pre_s_vsync", int'(s_vsync), 1);

        // Asynchronous reset mid-cycle: outputs revert before the next edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_hpos", int'(s_hpos), 6);
        chk("arst_s_vpos", int'(s_vpos), 6);
        chk("arst_s_hsync", int'(s_hsync), 0);
        chk("arst_s_vsync", int'(s_vsync), 0);
        chk("arst_s_disp", int'(s_disp), 0);
        chk("arst_d_hpos", int'(d_hpos), 799);
        chk("arst_d_vsync", int'(d_vsync), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_s_hpos", int'(s_hpos), 0);
        chk("restart_s_fs", int'(s_fs), 1);
        chk("restart_d_fs", int'(d_fs), 1);

`ifdef SKYKING_FRAME_CNT_EN
        chk("fc_first_frame", int'(s_fc), 0);
        repeat (49) @(negedge clk);
        chk("fc_second_fs", int'(s_fs), 1);
        chk("fc_second_frame", int'(s_fc), 1);
        repeat (256 * 49 - 49) @(negedge clk);
        chk("fc_wrap_fs", int'(s_fs), 1);
        chk("fc_wrap_value", int'(s_fc), 0);
`else
        repeat (100) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
